// File: rtl/serial_shift_receiver_pkg.sv
// Shared state encoding, default parameters and counter width helper for
// the serial_shift_receiver deserializer.
package serial_shift_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } rx_state_t;

  localparam int DEF_FRAME_BITS  = 64;
  localparam int DEF_IDLE_CYCLES = 64;
  localparam int DEF_SYNC_STAGES = 2;

  // Width needed to hold values 0..max_value inclusive.
  function automatic int cnt_width(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/serial_shift_receiver_sync_edge_detect.sv
// Synchronizer chain for an asynchronous input plus a one-cycle pulse on
// the rising edge of the synchronized level.
module sync_edge_detect
  import serial_shift_receiver_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_chain;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_chain <= '0;
      r_prev  <= 1'b0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
      r_prev  <= r_chain[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];
  assign o_rise = r_chain[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/serial_shift_receiver.sv
// MSB-first two-wire shift stream receiver delimited by bit count and idle gap.
// Optional SERIAL_RX_ERRCNT_EN adds a saturating 8-bit err_count output.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for the first serial clock edge of a frame
// ST_SHIFT | collecting bits; gap expiry before a full frame is an error
// ST_GAP   | frame delivered; extra edges are overruns until the gap expires
module serial_shift_receiver
  import serial_shift_receiver_pkg::*;
#(
  parameter int FRAME_BITS  = DEF_FRAME_BITS,
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                sclk_in,
  input  logic                                sdt_in,
  output logic [FRAME_BITS-1:0]               frame,
  output logic                                frame_valid,
  output logic                                frame_err,
  output logic                                busy,
  output logic [cnt_width(FRAME_BITS)-1:0]    bit_count
`ifdef SERIAL_RX_ERRCNT_EN
  ,
  output logic [7:0]                          err_count
`endif
);

  localparam int CW = cnt_width(FRAME_BITS);
  localparam int GW = cnt_width(IDLE_CYCLES);

  rx_state_t              r_state;
  rx_state_t              w_state_nxt;
  logic [FRAME_BITS-1:0]  r_shift;
  logic [FRAME_BITS-1:0]  r_frame;
  logic [FRAME_BITS-1:0]  w_shift_word;
  logic [CW-1:0]          r_bit_count;
  logic [CW-1:0]          w_bit_count_nxt;
  logic [GW-1:0]          r_gap;
  logic [SYNC_STAGES-1:0] r_dt_sync;
  logic                   r_frame_valid;
  logic                   r_frame_err;
  logic                   w_rise;
  logic                   w_sclk_sync;
  logic                   w_sdt;
  logic                   w_gap_done;
  logic                   w_shift_en;
  logic                   w_load;
  logic                   w_valid_nxt;
  logic                   w_err_nxt;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .i_async(sclk_in),
    .o_sync (w_sclk_sync),
    .o_rise (w_rise)
  );

  // Data chain matches the clock chain depth so both arrive aligned.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dt_sync <= '0;
    end else begin
      r_dt_sync <= {r_dt_sync[SYNC_STAGES-2:0], sdt_in};
    end
  end

  assign w_sdt        = r_dt_sync[SYNC_STAGES-1];
  assign w_shift_word = {r_shift[FRAME_BITS-2:0], w_sdt};
  assign w_gap_done   = (r_gap == GW'(IDLE_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_gap <= '0;
    end else if (w_rise) begin
      r_gap <= '0;
    end else if (!w_gap_done) begin
      r_gap <= r_gap + GW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // An edge always takes priority over gap expiry in the same cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_count_nxt = r_bit_count;
    w_shift_en      = 1'b0;
    w_load          = 1'b0;
    w_valid_nxt     = 1'b0;
    w_err_nxt       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_shift_en      = 1'b1;
          w_bit_count_nxt = CW'(1);
          w_state_nxt     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_rise) begin
          w_shift_en      = 1'b1;
          w_bit_count_nxt = r_bit_count + CW'(1);
          if (r_bit_count == CW'(FRAME_BITS - 1)) begin
            w_load      = 1'b1;
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_GAP;
          end
        end else if (w_gap_done) begin
          w_err_nxt       = 1'b1;
          w_bit_count_nxt = '0;
          w_state_nxt     = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (w_rise) begin
          w_err_nxt = 1'b1;
        end else if (w_gap_done) begin
          w_bit_count_nxt = '0;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: begin
        w_bit_count_nxt = '0;
        w_state_nxt     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shift       <= '0;
      r_frame       <= '0;
      r_bit_count   <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      if (w_shift_en) begin
        r_shift <= w_shift_word;
      end
      if (w_load) begin
        r_frame <= w_shift_word;
      end
      r_bit_count   <= w_bit_count_nxt;
      r_frame_valid <= w_valid_nxt;
      r_frame_err   <= w_err_nxt;
    end
  end

`ifdef SERIAL_RX_ERRCNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err_count <= '0;
    end else if (w_err_nxt && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`endif

  assign frame       = r_frame;
  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;
  assign busy        = (r_state != ST_IDLE);
  assign bit_count   = r_bit_count;

endmodule

// File: tb/tb_serial_shift_receiver.sv
// Randomized bench for serial_shift_receiver; expected results come from a
// burst-level model (bit count per burst decides valid/err counts and frame).
`timescale 1ns/1ps
module tb_serial_shift_receiver;

  localparam int FB = 64;
  localparam int IC = 64;
  localparam int SS = 2;
  localparam int CW = $clog2(FB + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sclk_in = 1'b0;
  logic          sdt_in = 1'b0;
  logic [FB-1:0] frame;
  logic          frame_valid;
  logic          frame_err;
  logic          busy;
  logic [CW-1:0] bit_count;
`ifdef SERIAL_RX_ERRCNT_EN
  logic [7:0]    err_count;
`endif

  serial_shift_receiver #(
    .FRAME_BITS (FB),
    .IDLE_CYCLES(IC),
    .SYNC_STAGES(SS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sclk_in    (sclk_in),
    .sdt_in     (sdt_in),
    .frame      (frame),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .busy       (busy),
    .bit_count  (bit_count)
`ifdef SERIAL_RX_ERRCNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Pulse monitor, sampled on the falling clock edge.
  int            n_valid = 0;
  int            n_err = 0;
  int            n_both = 0;
  int            valid_lat = 0;
  int            err_lat = 0;
  logic [FB-1:0] cap_frame = '0;
  int            last_rise = 0;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      n_valid++;
      cap_frame = frame;
      valid_lat = cyc - last_rise;
    end
    if (frame_err === 1'b1) begin
      n_err++;
      err_lat = cyc - last_rise;
    end
    if (frame_valid === 1'b1 && frame_err === 1'b1) n_both++;
  end

  logic [FB-1:0] exp_frame = '0;

  task automatic send_bit(input logic b, input int half, input int exp_cnt);
    sdt_in = b;
    repeat (half) @(negedge clk);
    if (exp_cnt >= 0) check_eq("bit_count", 64'(bit_count), 64'(exp_cnt));
    sclk_in   = 1'b1;
    last_rise = cyc;
    repeat (half) @(negedge clk);
    sclk_in = 1'b0;
  endtask

  // One burst of n bits from IDLE, then enough silence for the gap to expire.
  task automatic run_burst(input logic [FB-1:0] word, input int n, input int half);
    int v0, e0, b0, ev, ee;
    v0 = n_valid;
    e0 = n_err;
    b0 = n_both;
    for (int i = 0; i < n; i++) begin
      logic b;
      b = (i < FB) ? word[FB-1-i] : 1'($urandom);
      send_bit(b, half, (i < FB) ? i : FB);
      if (i == 0) begin
        repeat (1) @(negedge clk);
      end
      if (i == 1) check_eq("busy_mid", 64'(busy), 64'd1);
    end
    repeat (IC + SS + 12) @(negedge clk);
    if (n < FB) begin
      ev = 0;
      ee = 1;
    end else begin
      ev = 1;
      ee = n - FB;
      exp_frame = word;
    end
    check_eq("valid_count", 64'(n_valid - v0), 64'(ev));
    check_eq("err_count_pulses", 64'(n_err - e0), 64'(ee));
    check_eq("valid_err_overlap", 64'(n_both - b0), 64'd0);
    check_eq("frame", 64'(frame), 64'(exp_frame));
    check_eq("busy_after_gap", 64'(busy), 64'd0);
    check_eq("bit_count_after_gap", 64'(bit_count), 64'd0);
    if (ev == 1) check_eq("captured_frame", 64'(cap_frame), 64'(word));
    if (n == FB) check_eq("valid_latency", 64'(valid_lat), 64'(SS + 1));
    if (n < FB) check_eq("short_err_latency", 64'(err_lat), 64'(SS + IC + 2));
    if (n > FB) check_eq("overrun_err_latency", 64'(err_lat), 64'(SS + 1));
  endtask

  initial begin
    int v0, e0;
    // Reset held while the serial clock toggles.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sclk_in = ~sclk_in;
      sdt_in  = 1'b1;
      check_eq("rst_frame", 64'(frame), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_bit_count", 64'(bit_count), 64'd0);
    end
    sclk_in = 1'b0;
    sdt_in  = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst_no_valid", 64'(n_valid), 64'd0);
    check_eq("rst_no_err", 64'(n_err), 64'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("post_rst_busy", 64'(busy), 64'd0);

    run_burst(64'h0123_4567_89AB_CDEF, FB, 4);
    run_burst(64'hDEAD_BEEF_0000_0000, 10, 4);
    run_burst(64'hA5A5_5A5A_C3C3_3C3C, FB + 2, 4);
    run_burst({$urandom, $urandom}, FB, 4);

    // Reset in the middle of a frame.
    for (int i = 0; i < 30; i++) send_bit(1'($urandom), 4, i);
    v0 = n_valid;
    e0 = n_err;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("midrst_frame", 64'(frame), 64'd0);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_bit_count", 64'(bit_count), 64'd0);
    exp_frame = '0;
    rst = 1'b1;
    repeat (IC + 10) @(negedge clk);
    check_eq("midrst_no_valid", 64'(n_valid - v0), 64'd0);
    check_eq("midrst_no_err", 64'(n_err - e0), 64'd0);
    run_burst(64'hFFFF_0000_FFFF_0000, FB, 4);

    for (int k = 0; k < 14; k++) begin
      int sel, n, half;
      sel  = $urandom_range(0, 2);
      half = $urandom_range(SS + 1, 7);
      if (sel == 0) n = $urandom_range(1, FB - 1);
      else if (sel == 1) n = FB;
      else n = $urandom_range(FB + 1, FB + 4);
      run_burst({$urandom, $urandom}, n, half);
    end

`ifdef SERIAL_RX_ERRCNT_EN
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_frame = '0;
    @(negedge clk);
    check_eq("errcnt_reset", 64'(err_count), 64'd0);
    for (int k = 0; k < 300; k++) begin
      run_burst({$urandom, $urandom}, 1, SS + 1);
      if (k == 9) check_eq("errcnt_10", 64'(err_count), 64'd10);
    end
    check_eq("errcnt_saturated", 64'(err_count), 64'd255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_shift_receiver.md
# serial_shift_receiver

Deserializer for the two-wire clock/data shift stream (SEG_CLK/SEG_DT, LED_CLK/LED_DO style) that our segment and LED drivers emit. It oversamples the serial clock and data in the system clock domain, shifts bits in MSB-first, delimits frames by bit count and idle gap, and presents each completed frame as a parallel word with a one-cycle valid strobe. It sits on a loop-back or second board as the receiving end of the display shift protocol, and is also used as a bench monitor for the drivers.

## Interface
- FRAME_BITS, 64: bits per frame; range 8..256.
- IDLE_CYCLES, 64: clk cycles with no serial clock rising edge that close or abort a frame; ≥4.
- SYNC_STAGES, 2: synchronizer depth on both serial inputs; ≥2.

- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low (asserted when 0, sampled on clk rising edge).
- sclk_in  in  1  serial shift clock, asynchronous, idles low.
- sdt_in  in  1  serial data, valid at sclk_in rising edge.
- frame  out  FRAME_BITS  last complete frame; first received bit in frame[FRAME_BITS-1].
- frame_valid  out  1  one-cycle pulse when frame updates.
- frame_err  out  1  one-cycle pulse on short frame or overrun.
- busy  out  1  high while in SHIFT or GAP.
- bit_count  out  clog2(FRAME_BITS+1)  bits shifted so far in current frame.

## Operation
- sclk_in and sdt_in pass through identical SYNC_STAGES flop chains; rising edge = synced sclk high and previous synced sclk low. Data sampled from synced sdt at the same cycle the edge is detected.
- Gap timer counts clk cycles since last detected edge, clears on every edge, saturates at IDLE_CYCLES.
- States: IDLE, SHIFT, GAP.
  - IDLE: edge -> shift bit in, bit_count=1, go SHIFT.
  - SHIFT: edge -> shift, bit_count+1. On the edge that makes bit_count == FRAME_BITS: copy shift register to frame, pulse frame_valid next cycle, go GAP. Gap timer reaches IDLE_CYCLES with 0 < bit_count < FRAME_BITS: discard, pulse frame_err, go IDLE, bit_count=0.
  - GAP: edges ignored for data; any edge pulses frame_err (overrun) and restarts gap timer. Timer reaches IDLE_CYCLES -> IDLE, bit_count=0.
- Edge and gap expiry in the same cycle: edge wins; timer restarts.
- frame holds its value until the next complete frame; short/overrun frames never alter it.
- frame_valid and frame_err never assert in the same cycle.

## Timing
- Reset values: frame=0, frame_valid=0, frame_err=0, busy=0, bit_count=0, state IDLE, synchronizer flops 0, gap timer 0.
- Reset asserted mid-frame: partial frame discarded, no strobe, all outputs to reset values next cycle.
- Input to edge-detect latency: SYNC_STAGES+1 clk cycles from sclk_in rising.
- frame_valid: exactly 1 clk after the final bit's detected edge; frame valid same cycle.
- frame_err (short): 1 clk after timer reaches IDLE_CYCLES.
- Serial clock high and low phases must each be ≥ SYNC_STAGES+1 clk cycles; sdt_in stable ≥ that long around sclk_in rising.

## Configuration
- SERIAL_RX_ERRCNT_EN defined: adds output err_count (8 bit), incremented on each frame_err pulse, saturating at 255, reset to 0.
- Undefined: err_count port and counter absent; all other behaviour identical.

## Structure
- Shared package: state encoding (IDLE/SHIFT/GAP constants), default FRAME_BITS/IDLE_CYCLES values, counter width helper.
- One sub-module: sync_edge_detect (synchronizer chain plus rising-edge pulse, SYNC_STAGES parameter), instantiated for sclk; data uses a plain chain of equal depth.

## Test plan
- Reset: hold rst=0 for 3 clk while toggling sclk_in -> all outputs 0, no strobes.
- Full frame: FRAME_BITS=64, send 0x0123456789ABCDEF MSB-first, sclk period 8 clk -> one frame_valid, frame=0x0123456789ABCDEF, busy low IDLE_CYCLES after last edge.
- Short frame: send 10 bits then idle -> frame_err pulse at IDLE_CYCLES after 10th edge, frame unchanged, bit_count back to 0.
- Overrun: send 66 bits back-to-back -> frame_valid after bit 64, frame_err on bit 65 and 66, next frame after gap captured correctly.
- Mid-frame reset: assert rst after 30 bits, then send full 0xFFFF_0000_FFFF_0000 -> only that frame reported.
- With SERIAL_RX_ERRCNT_EN: 300 short frames -> err_count stops at 255.
